// File: rtl/load_store_unit.sv
// Load/store unit: effective address, alignment check, one word-aligned memory access, load extension.
// Latency: 3 cycles accept->response on a hit, 1 cycle for misaligned/illegal, TIMEOUT_CYCLES+2 on timeout.
// Backpressure: one op in flight; req_ready only in IDLE, response held until resp_ready.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_is_store,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_base,
    input  logic [11:0]             req_offset,
    input  logic [DATA_WIDTH-1:0]   req_store_data,
    input  logic [4:0]              req_rd,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic [4:0]              resp_rd,
    output logic                    resp_is_load,
    output logic [1:0]              resp_err,
    output logic [ADDR_WIDTH-1:0]   dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_write_data,
    output logic                    dmem_read,
    output logic                    dmem_write,
    output logic [3:0]              dmem_byte_enable,
    input  logic [DATA_WIDTH-1:0]   dmem_read_data,
    input  logic                    dmem_ready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_FAULT = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // Only what the WAIT state needs to format the returning word.
    typedef struct packed {
        logic [1:0] ea_lo;
        logic [2:0] funct3;
        logic       is_store;
    } op_t;

    state_t                  state;
    op_t                     op;
    logic [CW-1:0]           wait_cnt;
    logic [ADDR_WIDTH-1:0]   ea;
    logic                    f3_legal;
    logic                    ea_aligned;

    function automatic logic legal_funct3(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // funct3[1:0] encodes access size for both signed and unsigned loads.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b01:   return !lo[0];
            2'b10:   return lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input logic is_store, input logic [1:0] size,
                                               input logic [1:0] lo);
        if (!is_store)
            return 4'b1111;
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic is_store, input logic [1:0] size,
                                              input logic [31:0] d);
        if (!is_store)
            return 32'h0;
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [31:0] s;
        s = word >> {lo, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b010:  return s;
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        ea         = req_base + {{(ADDR_WIDTH-12){req_offset[11]}}, req_offset};
        f3_legal   = legal_funct3(req_is_store, req_funct3);
        ea_aligned = is_aligned(req_funct3[1:0], ea[1:0]);
    end

    assign req_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            op               <= '0;
            wait_cnt         <= '0;
            resp_valid       <= 1'b0;
            resp_data        <= '0;
            resp_rd          <= '0;
            resp_is_load     <= 1'b0;
            resp_err         <= ERR_OK;
            dmem_addr        <= '0;
            dmem_write_data  <= '0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_byte_enable <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op.ea_lo     <= ea[1:0];
                        op.funct3    <= req_funct3;
                        op.is_store  <= req_is_store;
                        resp_rd      <= req_rd;
                        resp_is_load <= !req_is_store;
                        resp_data    <= '0;
                        if (!f3_legal) begin
                            resp_err   <= ERR_ILL;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else if (!ea_aligned) begin
                            resp_err   <= ERR_ALIGN;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            dmem_addr        <= {ea[ADDR_WIDTH-1:2], 2'b00};
                            dmem_read        <= !req_is_store;
                            dmem_write       <= req_is_store;
                            dmem_byte_enable <= lane_enable(req_is_store, req_funct3[1:0], ea[1:0]);
                            dmem_write_data  <= lane_data(req_is_store, req_funct3[1:0], req_store_data);
                            state            <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    dmem_read  <= 1'b0;
                    dmem_write <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (dmem_ready) begin
                        resp_data  <= op.is_store ? '0 : load_format(op.funct3, op.ea_lo, dmem_read_data);
                        resp_err   <= ERR_OK;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        resp_data  <= '0;
                        resp_err   <= ERR_FAULT;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
